// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the ADC sample averaging path.
package adc_pkg;

    localparam int ADC_DATA_W     = 8;
    localparam int AVG_LOG2_DEPTH = 3;

    typedef enum logic {
        AVG_FILL = 1'b0,
        AVG_RUN  = 1'b1
    } avg_state_t;

endpackage

// File: rtl/avg_ring_buffer.sv
// Window storage for the averager: returns the oldest entry and overwrites it
// with the new sample on the same edge.
module avg_ring_buffer
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LOG2_DEPTH = AVG_LOG2_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] oldest
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;

    assign oldest = mem[wr_ptr];

    // NOTE: the array is reset and cleared on purpose; zeroed entries make
    // the evicted sample read as 0 while the window is still filling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/adc_sample_averager.sv
// Moving-average filter over the last 2^LOG2_DEPTH ADC conversions with a
// rounded mean output and one-cycle valid strobe.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LOG2_DEPTH = AVG_LOG2_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_valid,
    input  logic                  clear,
    output logic [DATA_W-1:0]     avg_out,
    output logic                  avg_valid,
    output logic                  window_full,
    output logic [LOG2_DEPTH:0]   sample_count
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH + 1;
    localparam int CNT_W = LOG2_DEPTH + 1;

    avg_state_t        state;
    logic              accept;
    logic              avg_pending;
    logic [DATA_W-1:0] oldest;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic [SUM_W-1:0]  sum_rounded;

    assign accept      = sample_valid && !clear;
    // oldest is always part of sum, so the subtraction never wraps.
    assign sum_next    = sum + SUM_W'(sample_in) - SUM_W'(oldest);
    assign sum_rounded = sum + SUM_W'(1 << (LOG2_DEPTH - 1));

    avg_ring_buffer #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (accept),
        .wr_data (sample_in),
        .oldest  (oldest)
    );

    // NOTE: non-blocking throughout, so the output stage sees the sum
    // registered by the previous accept even when a new one lands this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= AVG_FILL;
            sample_count <= '0;
            sum          <= '0;
            avg_pending  <= 1'b0;
            avg_out      <= '0;
            avg_valid    <= 1'b0;
            window_full  <= 1'b0;
        end else if (clear) begin
            state        <= AVG_FILL;
            sample_count <= '0;
            sum          <= '0;
            avg_pending  <= 1'b0;
            avg_out      <= '0;
            avg_valid    <= 1'b0;
            window_full  <= 1'b0;
        end else begin
            avg_valid   <= avg_pending;
            avg_pending <= 1'b0;
            if (avg_pending) avg_out <= sum_rounded[LOG2_DEPTH +: DATA_W];

            if (accept) begin
                sum <= sum_next;
                if (state == AVG_RUN) begin
                    avg_pending <= 1'b1;
                end else begin
                    sample_count <= sample_count + 1'b1;
                    if (sample_count == CNT_W'(DEPTH - 1)) begin
                        state       <= AVG_RUN;
                        window_full <= 1'b1;
                        avg_pending <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based window-mean model.
module tb_adc_sample_averager;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic       window_full;
    logic [3:0] sample_count;

    int n_checks = 0;
    int n_fail   = 0;

    // model: samples accepted since reset/clear, newest at back, at most 8
    int win[$];
    bit pend     = 1'b0;
    int pend_avg = 0;
    int exp_avg  = 0;
    bit exp_valid = 1'b0;

    always #5 clk = ~clk;

    adc_sample_averager dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .window_full  (window_full),
        .sample_count (sample_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int window_mean();
        int s = 0;
        foreach (win[i]) s += win[i];
        return (s + 4) / 8;
    endfunction

    task automatic model_flush();
        win.delete();
        pend      = 1'b0;
        exp_avg   = 0;
        exp_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_count"}, sample_count, win.size());
        check({tag, "_full"},  window_full, (win.size() == 8) ? 1 : 0);
        check({tag, "_valid"}, avg_valid, exp_valid);
        check({tag, "_avg"},   avg_out, exp_avg);
    endtask

    // Drive one clock of inputs (from a negedge), update model, check at next negedge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic c);
        sample_valid = v;
        sample_in    = d;
        clear        = c;
        @(posedge clk);
        if (c) begin
            model_flush();
        end else begin
            exp_valid = pend;
            if (pend) exp_avg = pend_avg;
            pend = 1'b0;
            if (v) begin
                win.push_back(int'(d));
                if (win.size() > 8) void'(win.pop_front());
                if (win.size() == 8) begin
                    pend     = 1'b1;
                    pend_avg = window_mean();
                end
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        clear        = 1'b0;
        check_outputs("cyc");
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        model_flush();
        check_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic random_run(input int n, input int clr_one_in);
        for (int i = 0; i < n; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(1, clr_one_in) == 1) ? 1'b1 : 1'b0);
    endtask

    int t3_exp[8] = '{113, 125, 138, 150, 163, 175, 188, 200};
    int pulses;

    initial begin
        @(negedge clk);
        model_flush();
        check_outputs("por");
        reset = 1'b1;

        // warm up, then reset asynchronously mid-stream
        random_run(60, 1000);
        async_reset();

        // test 2: eight spaced strobes of 100
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 8'd100, 1'b0);
            for (int j = 0; j < 3; j++) cycle(1'b0, 8'($urandom), 1'b0);
        end
        check("t2_avg", avg_out, 100);
        check("t2_full", window_full, 1);

        // test 3: eight strobes of 200
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 8'd200, 1'b0);
            cycle(1'b0, 8'd0, 1'b0);
            check("t3_avg", avg_out, t3_exp[k]);
        end

        // test 4: back-to-back 255s then 0s
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, (k < 8) ? 8'd255 : 8'd0, 1'b0);
            if (avg_valid) pulses++;
            if (k == 8) check("t4_peak", avg_out, 255);
        end
        cycle(1'b0, 8'd0, 1'b0);
        if (avg_valid) pulses++;
        check("t4_pulses", pulses, 16);
        check("t4_final", avg_out, 0);

        // test 5: clear beats a simultaneous strobe
        cycle(1'b1, 8'd50, 1'b1);
        check("t5_count", sample_count, 0);
        check("t5_avg", avg_out, 0);
        for (int k = 0; k < 7; k++) cycle(1'b1, 8'($urandom), 1'b0);

        // test 6: pointer wrap evicts the first sample
        cycle(1'b0, 8'd0, 1'b1);
        for (int k = 8; k <= 15; k++) cycle(1'b1, 8'(k), 1'b0);
        cycle(1'b0, 8'd0, 1'b0);
        check("t6_avg12", avg_out, 12);
        cycle(1'b1, 8'd16, 1'b0);
        cycle(1'b0, 8'd0, 1'b0);
        check("t6_avg13", avg_out, 13);

        // random traffic with occasional clears and one more reset
        random_run(300, 40);
        async_reset();
        random_run(200, 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
Moving-average filter between the ADC0808 interface stage (8-bit conversion result plus a one-cycle conversion-done strobe) and the binary-to-BCD / seven-segment display path. It keeps a ring buffer of the last 2^LOG2_DEPTH samples and a running sum. It outputs a rounded window mean with a one-cycle valid strobe, which removes last-digit flicker on the display. It runs in the ADC clock domain (50 kHz tick) and is fully pipelined: it accepts a strobe on every cycle.

Parameters:
DATA_W, 8, sample and average width in bits
LOG2_DEPTH, 3, log2 of the window depth; D = 2^LOG2_DEPTH = 8

Ports:
clk  input  1  block clock, rising edge
reset  input  1  asynchronous, active-low reset
sample_in  input  DATA_W  ADC conversion result; sampled only when sample_valid=1
sample_valid  input  1  one-cycle strobe: sample_in holds a new conversion
clear  input  1  synchronous flush of window, sum and count; active-high
avg_out  output  DATA_W  rounded window mean; holds its value between updates
avg_valid  output  1  one-cycle pulse when avg_out has just been updated
window_full  output  1  high once D samples have been accepted since reset or clear
sample_count  output  LOG2_DEPTH+1  samples accepted; saturates at D

Behaviour:
- Reset (reset=0, asynchronous):
  - buffer entries, sum, wr_ptr, sample_count, avg_out, avg_valid and window_full all go to 0
  - state goes to FILL
- State machine, FILL and RUN:
  - FILL: sample_count < D. RUN: sample_count == D.
  - FILL -> RUN on the accept that makes the count reach D.
  - RUN -> FILL only on clear or reset.
- Accept: sample_valid=1 and clear=0 at a rising edge. On each accept, at that edge:
  - oldest = buf[wr_ptr]
  - buf[wr_ptr] <= sample_in
  - sum <= sum + sample_in - oldest
  - wr_ptr <= wr_ptr + 1, wrapping from D-1 to 0
  - sample_count increments, saturating at D
- oldest reads as 0 during FILL, because buffer entries are zeroed by reset and by clear.
- sum width is DATA_W+LOG2_DEPTH+1 bits, unsigned. It can never underflow because oldest is already contained in sum.
- Output stage, one edge after the accept edge:
  - avg_out <= (sum + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH, i.e. round-half-up
  - the maximum is (255*8+4)>>3 = 255, so no saturation logic is needed
- Latency: strobe at edge N -> avg_out/avg_valid registered at edge N+1, visible in the cycle after N+1.
- avg_valid pulses only for accepts made in RUN, including the accept that enters RUN.
  - Accepts in FILL update sum but leave avg_out at 0 and avg_valid low.
- Back-to-back strobes on consecutive cycles are each accepted. Each produces its own avg_valid pulse, one cycle later.
- clear=1 at an edge:
  - buffer, sum, wr_ptr, sample_count, avg_out and window_full go to 0; state goes to FILL
  - avg_valid goes low, cancelling any pending output update
  - clear wins over a simultaneous sample_valid; that sample is dropped
- window_full is high exactly when the state is RUN; it is registered.
- sample_in is ignored whenever sample_valid=0.
- Reset asserted mid-stream takes effect immediately; no partial-window output follows deassertion.

Decomposition:
- Shared package adc_pkg:
  - ADC_DATA_W = 8
  - AVG_LOG2_DEPTH = 3
  - state encoding: AVG_FILL = 1'b0, AVG_RUN = 1'b1
- One sub-module: avg_ring_buffer.
  - Holds the D x DATA_W register array and wr_ptr with wrap.
  - Read-oldest and write-new happen in the same cycle.
  - It takes clk, reset and a synchronous clear.
- Sum, count, state machine and the rounding/output stage stay in adc_sample_averager.

Test Plan:
1. Assert reset=0 mid-run, then release -> avg_out=0, avg_valid=0, window_full=0, sample_count=0; no avg_valid until 8 new accepts.
2. Eight strobes with sample_in=100, spaced 4 cycles -> no avg_valid for strobes 1-7; sample_count reaches 8; window_full rises; avg_valid pulses once, one cycle after the 8th accept edge, with avg_out=100.
3. Continue with eight strobes of 200 -> avg_out sequence 113, 125, 138, 150, 163, 175, 188, 200.
   - Derived as (100*(8-k)+200*k+4)>>3.
4. Eight strobes of 255 on consecutive cycles, then eight of 0 -> eight avg_valid pulses ending at 255, then a descending sequence ending at 0.
   - Checks the sum does not overflow or wrap, and that back-to-back strobes each produce a pulse.
5. In RUN, drive clear=1 together with sample_valid=1 and sample_in=50 -> sample dropped; sample_count=0, window_full=0, avg_out=0; the next 7 strobes produce no avg_valid.
6. Strobe pattern 8,9,10,...,15, then 16 -> avg_out = 12 (round of 11.5), then avg_out = 13 (sum 100, (100+4)>>3 = 13).
   - Checks wr_ptr wrap-around evicts the sample 8.
